svc_rv_sram_arbiter: RTL and testbench
======================================

// Module: svc_rv_sram_arbiter
//
// PURPOSE
// - Shares one svc_mem_sram-style port between NUM_M requesters, e.g. CPU
//   data bus, debug/loader and a DMA engine.
//   The SRAM has a combinational read address, registered read data and a
//   byte-strobed write.
// - Issues at most one access (read or write) per cycle and grants
//   round-robin.
// - Returns read data to the requester that issued the read, one cycle later.
//
// PARAMETERS
// - NUM_M  2   number of requesters (2..8)
// - AW     32  address width (byte address, passed through unchanged)
// - DW     32  data width; strobe width is DW/8
//
// PORTS
// - clk        in   1         clock
// - rst        in   1         synchronous, active-high reset
// - m_valid    in   NUM_M     request valid, one bit per requester
// - m_ready    out  NUM_M     request accepted this cycle (one-hot or zero)
// - m_write    in   NUM_M     1 = write, 0 = read
// - m_addr     in   NUM_M*AW  request address; requester i at [i*AW +: AW]
// - m_wdata    in   NUM_M*DW  write data
// - m_wstrb    in   NUM_M*DW/8  write byte strobes
// - m_rvalid   out  NUM_M     read data valid for requester i
// - m_rdata    out  DW        read data, shared by all requesters
// - sram_rd_addr  out  AW     SRAM read address
// - sram_rd_data  in   DW     SRAM read data, registered, valid 1 cycle after address
// - sram_wr_en    out  1      SRAM write enable
// - sram_wr_addr  out  AW     SRAM write address
// - sram_wr_data  out  DW     SRAM write data
// - sram_wr_strb  out  DW/8   SRAM write strobes
// - stat_wait     out  NUM_M*32  per-requester wait-cycle counters (SVC_RV_SRAM_ARB_STATS_EN)
//
// BEHAVIOUR
// - Grant: combinational round-robin over m_valid, starting at pri_ptr.
//   - m_ready[g] = 1 only for the granted requester g; all other bits are 0.
//   - Accept on m_valid[g] && m_ready[g].
//   - A requester may present a new request every cycle.
//   - A requester must hold its request stable while valid && !ready.
// - pri_ptr update: after an accept, pri_ptr <= (g+1) % NUM_M. With no
//   accept it holds.
// - A lone requester is never starved and is never given a bubble: it is
//   granted 100% of cycles.
// - Accepted write: same cycle, sram_wr_en = 1 and sram_wr_addr/data/strb
//   = requester g's fields.
// - Accepted read: same cycle, sram_rd_addr = m_addr[g].
//   - rd_owner <= g and rd_pend <= 1.
//   - Next cycle m_rvalid[rd_owner] = 1 and m_rdata = sram_rd_data.
// - Read latency is exactly 1 cycle. Back-to-back reads give back-to-back
//   rvalid, each to its own owner.
// - Idle cycle: sram_wr_en = 0. sram_rd_addr holds its last value, so SRAM
//   outputs do not toggle.
// - Write then read of the same address in consecutive cycles returns the
//   new data (SRAM write-first on registered read).
// - Reset (rst = 1), including mid-read:
//   - pri_ptr = 0, rd_pend = 0, m_rvalid = 0, m_ready = 0, sram_wr_en = 0.
//   - sram_rd_addr = 0, m_rdata = 0 (gated by rd_pend), stat_wait = 0.
//   - A read accepted in the cycle rst asserts never produces rvalid.
// - m_rdata is 0 whenever no m_rvalid bit is set.
//
// CONFIGURATION
// - SVC_RV_SRAM_ARB_STATS_EN defined: stat_wait[i] counts cycles with
//   m_valid[i] && !m_ready[i]. It saturates at 32'hFFFF_FFFF and clears
//   on rst.
// - SVC_RV_SRAM_ARB_STATS_EN undefined: the port still exists, is tied to
//   0 and no counter flops are built.
//
// STRUCTURE
// - Package svc_rv_sram_arb_pkg:
//   - MAX_M = 8
//   - typedef logic [2:0] m_id_t (owner index)
//   - function rr_next(ptr, n)
// - Sub-module svc_rr_arbiter #(N): req[N], ptr, and accept in; one-hot
//   grant and grant_id out. It owns the pri_ptr register.
// - Top level holds the request mux, the rd_owner/rd_pend pipe register
//   and the optional counters.
//
// TESTING
// - Only m0 reads 0x10, 0x14, 0x18 on consecutive cycles.
//   Expect m_ready[0]=1 for all three and m_rvalid[0] on cycles 1..3.
//   Expect data equal to preloaded 0xA0, 0xB0, 0xC0.
// - m0 and m1 both hold valid for 6 cycles.
//   Grants alternate 0,1,0,1,0,1 from reset.
//   Each m_rvalid goes only to its issuer.
// - m1 writes 0xDEADBEEF with wstrb=4'b0011 to 0x20, then m0 reads 0x20
//   next cycle. Expect rdata 0x0000BEEF (old word 0).
// - m0 requests are all writes and m1 requests are all reads, issued
//   simultaneously. m_rvalid[1] appears only the cycle after m1's grant.
//   sram_wr_en is never high in an m1 grant cycle.
// - Assert rst in the cycle after a read accept.
//   Expect m_rvalid = 0 and pri_ptr back to 0: a simultaneous m0/m1
//   request then grants m0 first.
// - With STATS_EN, m1 waits 3 cycles behind an m0 stream.
//   Expect stat_wait[1] = 3 and stat_wait[0] = 0; rst clears both.

Source files
------------

// File: rtl/svc_rv_sram_arb_pkg.sv
// Shared types and helpers for the round-robin SRAM arbiter.
package svc_rv_sram_arb_pkg;

  localparam int unsigned MAX_M = 8;

  typedef logic [2:0] m_id_t;

  function automatic m_id_t rr_next(input m_id_t ptr, input int unsigned n);
    int unsigned nxt;
    nxt = 32'(ptr) + 32'd1;
    if (nxt >= n) nxt = 0;
    return m_id_t'(nxt);
  endfunction

endpackage

// File: rtl/svc_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from the priority pointer,
// which advances past the granted requester on accept.
module svc_rr_arbiter
  import svc_rv_sram_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] grant,
  output m_id_t        grant_id
);

  m_id_t pri_ptr_q;
  logic  found;

  // First pass covers [pri_ptr, N), second pass wraps to [0, pri_ptr).
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i] && (m_id_t'(i) >= pri_ptr_q)) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = m_id_t'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        grant_id = m_id_t'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pri_ptr_q <= '0;
    end else if (accept) begin
      pri_ptr_q <= rr_next(grant_id, N);
    end
  end

endmodule

// File: rtl/svc_rv_sram_arbiter.sv
// Shares one SRAM port (registered read, strobed write) between NUM_M requesters.
// Optional per-requester wait counters: define SVC_RV_SRAM_ARB_STATS_EN.
module svc_rv_sram_arbiter
  import svc_rv_sram_arb_pkg::*;
#(
  parameter int unsigned NUM_M = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M-1:0]      m_valid,
  output logic [NUM_M-1:0]      m_ready,
  input  logic [NUM_M-1:0]      m_write,
  input  logic [NUM_M*AW-1:0]   m_addr,
  input  logic [NUM_M*DW-1:0]   m_wdata,
  input  logic [NUM_M*DW/8-1:0] m_wstrb,
  output logic [NUM_M-1:0]      m_rvalid,
  output logic [DW-1:0]         m_rdata,
  output logic [AW-1:0]         sram_rd_addr,
  input  logic [DW-1:0]         sram_rd_data,
  output logic                  sram_wr_en,
  output logic [AW-1:0]         sram_wr_addr,
  output logic [DW-1:0]         sram_wr_data,
  output logic [DW/8-1:0]       sram_wr_strb,
  output logic [NUM_M*32-1:0]   stat_wait
);

  localparam int unsigned SW = DW / 8;

  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] grant;
  m_id_t            grant_id;
  logic             accept;
  logic             acc_rd;
  logic             acc_wr;

  logic             sel_write;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic [SW-1:0]    sel_wstrb;

  logic             rd_pend_q;
  m_id_t            rd_owner_q;
  logic [AW-1:0]    rd_addr_q;
  logic             rvalid;

  // Reset masks requests so nothing is granted while rst is high.
  assign req = rst ? '0 : m_valid;

  svc_rr_arbiter #(
    .N (NUM_M)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign m_ready = grant;
  assign accept  = |grant;

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      if (grant[i]) begin
        sel_write = m_write[i];
        sel_addr  = m_addr[i*AW +: AW];
        sel_wdata = m_wdata[i*DW +: DW];
        sel_wstrb = m_wstrb[i*SW +: SW];
      end
    end
  end

  assign acc_rd = accept & ~sel_write;
  assign acc_wr = accept & sel_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      rd_pend_q <= acc_rd;
      if (acc_rd) begin
        rd_owner_q <= grant_id;
        rd_addr_q  <= sel_addr;
      end
    end
  end

  // Read address parks on the last read so the SRAM output stays quiet when idle.
  assign sram_rd_addr = rst ? '0 : (acc_rd ? sel_addr : rd_addr_q);
  assign sram_wr_en   = acc_wr;
  assign sram_wr_addr = sel_addr;
  assign sram_wr_data = sel_wdata;
  assign sram_wr_strb = sel_wstrb;

  // A read in flight when rst asserts is dropped.
  assign rvalid  = rd_pend_q & ~rst;
  assign m_rdata = rvalid ? sram_rd_data : '0;

  always_comb begin
    m_rvalid = '0;
    for (int i = 0; i < int'(NUM_M); i++) begin
      m_rvalid[i] = rvalid && (rd_owner_q == m_id_t'(i));
    end
  end

`ifdef SVC_RV_SRAM_ARB_STATS_EN
  for (genvar i = 0; i < int'(NUM_M); i++) begin : g_stat
    logic [31:0] wait_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        wait_q <= '0;
      end else if (m_valid[i] && !m_ready[i] && (wait_q != '1)) begin
        wait_q <= wait_q + 32'd1;
      end
    end
    assign stat_wait[i*32 +: 32] = wait_q;
  end
`else
  assign stat_wait = '0;
`endif

endmodule

// File: tb/tb_svc_rv_sram_arbiter.sv
// Scoreboard bench for svc_rv_sram_arbiter with a write-first registered-read SRAM model.
module tb_svc_rv_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_valid = '0;
  logic [1:0]  m_ready;
  logic [1:0]  m_write = '0;
  logic [63:0] m_addr  = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wstrb = '0;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] sram_rd_addr;
  logic [31:0] sram_rd_data = '0;
  logic        sram_wr_en;
  logic [31:0] sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic [3:0]  sram_wr_strb;
  logic [63:0] stat_wait;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] mem [256];

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t exp_q[$];

  svc_rv_sram_arbiter #(
    .NUM_M (2),
    .AW    (32),
    .DW    (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_write      (m_write),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .sram_wr_strb (sram_wr_strb),
    .stat_wait    (stat_wait)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: reloaded on reset; the write lands before the read sample (write-first).
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] = '0;
      mem[4]  = 32'h0000_00A0;
      mem[5]  = 32'h0000_00B0;
      mem[6]  = 32'h0000_00C0;
      mem[12] = 32'h0000_1111;
      mem[13] = 32'h0000_2222;
      mem[14] = 32'h0000_3333;
      mem[15] = 32'h0000_4444;
    end else if (sram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wr_strb[b]) mem[sram_wr_addr[9:2]][b*8 +: 8] = sram_wr_data[b*8 +: 8];
    end
    sram_rd_data <= mem[sram_rd_addr[9:2]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rvalid pops the oldest outstanding read and checks owner, data, timing.
  always @(negedge clk) begin
    rsp_t e;
    if (m_rvalid != 2'b00) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rvalid: got %b expected 00", m_rvalid);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_owner", 64'(m_rvalid), 64'(e.owner));
        chk("rdata", 64'(m_rdata), 64'(e.data));
        chk("rvalid_cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("idle_rdata_zero", 64'(m_rdata), 64'd0);
      if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_rvalid: got none at cycle %0d expected owner %b data %0h",
                 cyc, e.owner, e.data);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd_addr = '0;
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] w, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] exp_rdy,
                      input logic [31:0] exp_rd, input bit push, input string name);
    int g;
    logic [31:0] ga;
    @(posedge clk);
    #1;
    m_valid = v;
    m_write = w;
    m_addr  = {a1, a0};
    m_wdata = {d1, d0};
    m_wstrb = {s1, s0};
    @(negedge clk);
    chk({name, "_ready"}, 64'(m_ready), 64'(exp_rdy));
    if (exp_rdy == 2'b00) begin
      chk({name, "_idle_wr_en"}, 64'(sram_wr_en), 64'd0);
      chk({name, "_idle_rd_addr_hold"}, 64'(sram_rd_addr), 64'(last_rd_addr));
    end else begin
      g  = exp_rdy[1] ? 1 : 0;
      ga = (g == 1) ? a1 : a0;
      if (w[g]) begin
        chk({name, "_wr_en"}, 64'(sram_wr_en), 64'd1);
        chk({name, "_wr_addr"}, 64'(sram_wr_addr), 64'(ga));
        chk({name, "_wr_data"}, 64'(sram_wr_data), 64'((g == 1) ? d1 : d0));
        chk({name, "_wr_strb"}, 64'(sram_wr_strb), 64'((g == 1) ? s1 : s0));
      end else begin
        chk({name, "_rd_no_wr_en"}, 64'(sram_wr_en), 64'd0);
        chk({name, "_rd_addr"}, 64'(sram_rd_addr), 64'(ga));
        last_rd_addr = ga;
        if (push) exp_q.push_back('{owner: exp_rdy, data: exp_rd, due: cyc + 1});
      end
    end
  endtask

  task automatic idle(input string name);
    step(2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 0, 1'b0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within bound");
    $fatal(1);
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_ready", 64'(m_ready), 64'd0);
    chk("reset_rvalid", 64'(m_rvalid), 64'd0);
    chk("reset_stat", stat_wait, 64'd0);

    // Lone requester: three back-to-back reads, no bubbles.
    step(2'b01, 2'b00, 32'h10, 0, 0, 0, 0, 0, 2'b01, 32'hA0, 1'b1, "lone0");
    step(2'b01, 2'b00, 32'h14, 0, 0, 0, 0, 0, 2'b01, 32'hB0, 1'b1, "lone1");
    step(2'b01, 2'b00, 32'h18, 0, 0, 0, 0, 0, 2'b01, 32'hC0, 1'b1, "lone2");
    idle("lone_idle");
    idle("lone_idle2");

    // Two contending readers alternate 0,1,0,1,0,1 from reset.
    do_reset();
    step(2'b11, 2'b00, 32'h30, 32'h34, 0, 0, 0, 0, 2'b01, 32'h1111, 1'b1, "alt0");
    step(2'b11, 2'b00, 32'h38, 32'h34, 0, 0, 0, 0, 2'b10, 32'h2222, 1'b1, "alt1");
    step(2'b11, 2'b00, 32'h38, 32'h3C, 0, 0, 0, 0, 2'b01, 32'h3333, 1'b1, "alt2");
    step(2'b11, 2'b00, 32'h30, 32'h3C, 0, 0, 0, 0, 2'b10, 32'h4444, 1'b1, "alt3");
    step(2'b11, 2'b00, 32'h30, 32'h34, 0, 0, 0, 0, 2'b01, 32'h1111, 1'b1, "alt4");
    step(2'b11, 2'b00, 32'h38, 32'h34, 0, 0, 0, 0, 2'b10, 32'h2222, 1'b1, "alt5");
    idle("alt_idle");

    // Partial-strobe write by m1 then immediate read by m0.
    do_reset();
    step(2'b10, 2'b10, 0, 32'h20, 0, 32'hDEADBEEF, 4'h0, 4'b0011, 2'b10, 0, 1'b0, "wr_m1");
    step(2'b01, 2'b00, 32'h20, 0, 0, 0, 0, 0, 2'b01, 32'h0000BEEF, 1'b1, "rd_after_wr");
    idle("wr_rd_idle");

    // m0 writes while m1 reads.
    do_reset();
    step(2'b11, 2'b01, 32'h40, 32'h10, 32'h11112222, 0, 4'hF, 0, 2'b01, 0, 1'b0, "mix0");
    step(2'b11, 2'b01, 32'h44, 32'h10, 32'h33334444, 0, 4'hF, 0, 2'b10, 32'hA0, 1'b1, "mix1");
    step(2'b11, 2'b01, 32'h44, 32'h14, 32'h33334444, 0, 4'hF, 0, 2'b01, 0, 1'b0, "mix2");
    step(2'b11, 2'b01, 32'h48, 32'h14, 32'h55556666, 0, 4'hF, 0, 2'b10, 32'hB0, 1'b1, "mix3");
    idle("mix_idle");
    step(2'b01, 2'b00, 32'h40, 0, 0, 0, 0, 0, 2'b01, 32'h11112222, 1'b1, "mix_readback");
    idle("mix_idle2");

    // Reset in the cycle after a read accept drops the read and resets the pointer.
    do_reset();
    step(2'b01, 2'b00, 32'h10, 0, 0, 0, 0, 0, 2'b01, 0, 1'b0, "pre_rst_rd");
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_valid = 2'b11;
    m_write = 2'b00;
    m_addr  = {32'h18, 32'h14};
    @(negedge clk);
    chk("midrst_rvalid", 64'(m_rvalid), 64'd0);
    chk("midrst_ready", 64'(m_ready), 64'd0);
    chk("midrst_wr_en", 64'(sram_wr_en), 64'd0);
    chk("midrst_rd_addr", 64'(sram_rd_addr), 64'd0);
    chk("midrst_rdata", 64'(m_rdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = 2'b00;
    last_rd_addr = '0;
    step(2'b11, 2'b00, 32'h14, 32'h18, 0, 0, 0, 0, 2'b01, 32'hB0, 1'b1, "post_rst0");
    step(2'b11, 2'b00, 32'h14, 32'h18, 0, 0, 0, 0, 2'b10, 32'hC0, 1'b1, "post_rst1");
    idle("post_rst_idle");

    // m1 loses three contended cycles to m0; m0 never waits.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      step(2'b11, 2'b01, 32'h50, 32'h10, 32'h1, 0, 4'hF, 0, 2'b01, 0, 1'b0, "stat_both");
      step(2'b10, 2'b00, 0, 32'h10, 0, 0, 0, 0, 2'b10, 32'hA0, 1'b1, "stat_m1");
    end
    idle("stat_idle");
`ifdef SVC_RV_SRAM_ARB_STATS_EN
    chk("stat_wait1", stat_wait[63:32], 64'd3);
    chk("stat_wait0", stat_wait[31:0], 64'd0);
`else
    chk("stat_wait_tied", stat_wait, 64'd0);
`endif
    do_reset();
    @(negedge clk);
    chk("stat_cleared", stat_wait, 64'd0);

    idle("final_idle");
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
